rom_ddr_loader: RTL

ROM_DDR_LOADER -- requirements
Module: rom_ddr_loader

---
 rtl/rom_ddr_loader_if.sv | 47 ++++
 rtl/rom_ddr_loader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/rom_ddr_loader_if.sv
// ----------------------------------------------------------------------------
// rom_ddr_loader_if
// Bus bundle between the loader and its ROM / DDR write port.
//   rom_addr        loader -> ROM    16-bit read address
//   rom_data        ROM -> loader    8*PIX_W read data
//   mem_data_wr1    loader -> DDR    256-bit write data
//   mem_data_rd1    DDR -> loader    256-bit read data (unused by the loader)
//   mem_data_addr1  loader -> DDR    28-bit write address
//   mem_rw_data1    loader -> DDR    1 = write
//   mem_valid_data1 loader -> DDR    write request valid
//   mem_ready_data1 DDR -> loader    write request accepted
// Modports: master = loader side, slave = ROM/DDR side.
// ----------------------------------------------------------------------------
interface rom_ddr_loader_if #(
   parameter int PIX_W = 8
);
   logic [15:0]        rom_addr;
   logic [8*PIX_W-1:0] rom_data;
   logic [255:0]       mem_data_wr1;
   logic [255:0]       mem_data_rd1;
   logic [27:0]        mem_data_addr1;
   logic               mem_rw_data1;
   logic               mem_valid_data1;
   logic               mem_ready_data1;

   modport master (
      output rom_addr,
      input  rom_data,
      output mem_data_wr1,
      input  mem_data_rd1,
      output mem_data_addr1,
      output mem_rw_data1,
      output mem_valid_data1,
      input  mem_ready_data1
   );

   modport slave (
      input  rom_addr,
      output rom_data,
      input  mem_data_wr1,
      output mem_data_rd1,
      input  mem_data_addr1,
      input  mem_rw_data1,
      input  mem_valid_data1,
      output mem_ready_data1
   );
endinterface

// File: rtl/rom_ddr_loader.sv
// ----------------------------------------------------------------------------
// rom_ddr_loader
// Copies NUM_WORDS ROM words into DDR starting at BASE_ADDR, stepping the
// address by ADDR_STEP per accepted write. Each ROM word holds eight PIX_W
// pixels, each widened (zero- or sign-extended) into a 32-bit DDR slot.
// A small prefetch FIFO decouples ROM reads from DDR back-pressure.
// Ports:
//   clk    sole clock, rising edge
//   rst    asynchronous active-low reset
//   start  one-cycle run request (honoured only when idle)
//   busy   run in progress
//   done   one-cycle pulse at run end
//   error  sticky watchdog abort flag (always 0 without the watchdog)
//   bus    rom_ddr_loader_if master modport (ROM read + DDR write port)
// Optional feature: define ROM_DDR_LOADER_TIMEOUT_EN to enable the ready
// watchdog (TIMEOUT_CYC stalled cycles abort the run and set error).
// ----------------------------------------------------------------------------
module rom_ddr_loader #(
   parameter int          PIX_W       = 8,
   parameter int          NUM_WORDS   = 38400,
   parameter logic [27:0] BASE_ADDR   = 28'h1000000,
   parameter int          ADDR_STEP   = 8,
   parameter int          ROM_LAT     = 1,
   parameter int          FIFO_DEPTH  = 4,
   parameter int          SIGN_EXT    = 0,
   parameter int          TIMEOUT_CYC = 1024
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             error,
   rom_ddr_loader_if.master bus
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [15:0]         rom_addr_q, rom_addr_d;
   logic [16:0]         issued_q, issued_d;
   logic [16:0]         acc_q, acc_d;
   logic [ROM_LAT-1:0]  rd_pipe_q, rd_pipe_d;
   logic [255:0]        fifo_mem_q [FIFO_DEPTH];
   logic [255:0]        fifo_mem_d [FIFO_DEPTH];
   logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]       fifo_cnt_q, fifo_cnt_d;
   logic                valid_q, valid_d;
   logic [255:0]        data_q, data_d;
   logic [27:0]         addr_q, addr_d;
   logic                error_q, error_d;

   logic [255:0]        packed_word;
   logic                issue, capture, accept, last_accept, pop, timeout;
   int                  inflight;
   logic                unused_rd;

`ifdef ROM_DDR_LOADER_TIMEOUT_EN
   logic [31:0]         wd_q, wd_d;
`endif

   assign bus.rom_addr        = rom_addr_q;
   assign bus.mem_data_wr1    = data_q;
   assign bus.mem_data_addr1  = addr_q;
   assign bus.mem_valid_data1 = valid_q;
   assign bus.mem_rw_data1    = 1'b1;
   assign unused_rd           = ^bus.mem_data_rd1;

   // Pixel k of the ROM word lands in 32-bit slot k; bits above PIX_W are
   // filled with the pixel MSB when SIGN_EXT is set, else with zero.
   always_comb begin
      packed_word = '0;
      for (int unsigned k = 0; k < 8; k++) begin
         for (int unsigned b = 0; b < 32; b++) begin
            if (b < PIX_W)
               packed_word[32*k+b] = bus.rom_data[PIX_W*k+b];
            else
               packed_word[32*k+b] = (SIGN_EXT != 0) && bus.rom_data[PIX_W*k+PIX_W-1];
         end
      end
   end

   always_comb begin
      inflight = 0;
      for (int unsigned i = 0; i < ROM_LAT; i++)
         inflight = inflight + int'(rd_pipe_q[i]);
   end

   // Issue only while FIFO occupancy plus reads still in the ROM pipe leave
   // room, so every captured word is guaranteed a free FIFO slot.
   assign issue       = (state_q == S_RUN) && (issued_q < 17'(NUM_WORDS)) &&
                        ((int'(fifo_cnt_q) + inflight) < FIFO_DEPTH);
   assign capture     = (state_q == S_RUN) && rd_pipe_q[ROM_LAT-1];
   assign accept      = (state_q == S_RUN) && valid_q && bus.mem_ready_data1;
   assign last_accept = accept && (acc_q == 17'(NUM_WORDS - 1));
   assign pop         = (state_q == S_RUN) && (!valid_q || accept) && (fifo_cnt_q != '0);

`ifdef ROM_DDR_LOADER_TIMEOUT_EN
   assign timeout = (state_q == S_RUN) && valid_q && !bus.mem_ready_data1 &&
                    (wd_q == 32'(TIMEOUT_CYC - 1));
   assign error   = error_q;
`else
   assign timeout = 1'b0;
   assign error   = 1'b0;
`endif

   // FSM: state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = S_RUN;
         S_RUN:   if (last_accept || timeout) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      busy = (state_q == S_RUN);
      done = (state_q == S_DONE);
   end

   // Datapath next-state
   always_comb begin
      rom_addr_d = rom_addr_q;
      issued_d   = issued_q;
      acc_d      = acc_q;
      rd_pipe_d  = rd_pipe_q;
      fifo_mem_d = fifo_mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      fifo_cnt_d = fifo_cnt_q;
      valid_d    = valid_q;
      data_d     = data_q;
      addr_d     = addr_q;
      error_d    = error_q;
`ifdef ROM_DDR_LOADER_TIMEOUT_EN
      wd_d       = '0;
`endif
      if (state_q == S_IDLE && start) begin
         rom_addr_d = '0;
         issued_d   = '0;
         acc_d      = '0;
         rd_pipe_d  = '0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         fifo_cnt_d = '0;
         valid_d    = 1'b0;
         addr_d     = BASE_ADDR;
         error_d    = 1'b0;
      end else if (state_q == S_RUN) begin
         rd_pipe_d = ROM_LAT'({rd_pipe_q, issue});
         if (issue) begin
            rom_addr_d = rom_addr_q + 16'd1;
            issued_d   = issued_q + 17'd1;
         end
         if (capture) begin
            fifo_mem_d[wr_ptr_q] = packed_word;
            wr_ptr_d             = wr_ptr_q + PW'(1);
         end
         if (accept) begin
            addr_d = addr_q + 28'(ADDR_STEP);
            acc_d  = acc_q + 17'd1;
         end
         // Output register refills on the accepting edge when data is
         // waiting, giving one word per cycle back-to-back.
         if (!valid_q || accept) begin
            if (pop) begin
               data_d   = fifo_mem_q[rd_ptr_q];
               rd_ptr_d = rd_ptr_q + PW'(1);
               valid_d  = 1'b1;
            end else begin
               valid_d  = 1'b0;
            end
         end
         fifo_cnt_d = fifo_cnt_q + CW'(capture) - CW'(pop);
`ifdef ROM_DDR_LOADER_TIMEOUT_EN
         if (valid_q && !bus.mem_ready_data1) wd_d = wd_q + 32'd1;
`endif
         if (timeout) begin
            valid_d    = 1'b0;
            rd_pipe_d  = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fifo_cnt_d = '0;
            error_d    = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rom_addr_q <= '0;
         issued_q   <= '0;
         acc_q      <= '0;
         rd_pipe_q  <= '0;
         fifo_mem_q <= '{default: '0};
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fifo_cnt_q <= '0;
         valid_q    <= 1'b0;
         data_q     <= '0;
         addr_q     <= BASE_ADDR;
         error_q    <= 1'b0;
      end else begin
         rom_addr_q <= rom_addr_d;
         issued_q   <= issued_d;
         acc_q      <= acc_d;
         rd_pipe_q  <= rd_pipe_d;
         fifo_mem_q <= fifo_mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         fifo_cnt_q <= fifo_cnt_d;
         valid_q    <= valid_d;
         data_q     <= data_d;
         addr_q     <= addr_d;
         error_q    <= error_d;
      end
   end

`ifdef ROM_DDR_LOADER_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) wd_q <= '0;
      else      wd_q <= wd_d;
   end
`endif
endmodule
